// File: rtl/mem_port_sequencer_pkg.sv
// Package for the memory port sequencer.
// Holds the core's existing memory operation codes (MEM_OP_*, MEM_RD_*, MEM_WR_*),
// the sequencer FSM state and owner encodings, the memory command bundle type,
// and small helpers that say whether a load/store width code is one the port can issue.
package mem_port_sequencer_pkg;

    // Control-unit memory operation codes
    localparam logic [1:0] MEM_OP_NONE  = 2'd0;
    localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
    localparam logic [1:0] MEM_OP_STORE = 2'd2;

    // Load width / signedness codes
    localparam logic [2:0] MEM_RD_NONE = 3'd0;
    localparam logic [2:0] MEM_RD_LB   = 3'd1;
    localparam logic [2:0] MEM_RD_LH   = 3'd2;
    localparam logic [2:0] MEM_RD_LW   = 3'd3;
    localparam logic [2:0] MEM_RD_LBU  = 3'd4;
    localparam logic [2:0] MEM_RD_LHU  = 3'd5;

    // Store width codes, expressed as lane-0 based byte masks
    localparam logic [3:0] MEM_WR_NONE = 4'b0000;
    localparam logic [3:0] MEM_WR_SB   = 4'b0001;
    localparam logic [3:0] MEM_WR_SH   = 4'b0011;
    localparam logic [3:0] MEM_WR_SW   = 4'b1111;

    // Sequencer FSM states
    localparam logic [1:0] SEQ_IDLE = 2'd0;
    localparam logic [1:0] SEQ_BUSY = 2'd1;
    localparam logic [1:0] SEQ_RESP = 2'd2;

    // Which requester owns the access in flight
    localparam logic SEQ_OWNER_IF = 1'b0;
    localparam logic SEQ_OWNER_D  = 1'b1;

    // One memory command as launched towards the memory
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_cmd_t;

    // True for load codes that describe a real access
    function automatic logic rd_code_valid(input logic [2:0] code);
        logic ok;
        case (code)
            MEM_RD_LB, MEM_RD_LH, MEM_RD_LW, MEM_RD_LBU, MEM_RD_LHU: ok = 1'b1;
            default:                                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True for store codes that describe a real access
    function automatic logic wr_code_valid(input logic [3:0] code);
        logic ok;
        case (code)
            MEM_WR_SB, MEM_WR_SH, MEM_WR_SW: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_port_sequencer_if.sv
// Bus bundle of the memory port sequencer.
// Groups the fetch requester (if_*), the data requester (d_*) and the memory
// side (m_*) signals.
//   master : the sequencer's view (drives done/err/rdata and the m_* command).
//   slave  : the environment's view (core requesters plus the memory).
interface mem_port_sequencer_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic [1:0]  d_op;
    logic [2:0]  d_read_type;
    logic [3:0]  d_wmask;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    modport master (
        input  if_req, if_addr,
        output if_done, if_rdata, if_err,
        input  d_req, d_op, d_read_type, d_wmask, d_addr, d_wdata,
        output d_done, d_rdata, d_err,
        output m_req, m_we, m_addr, m_be, m_wdata,
        input  m_ready, m_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_done, if_rdata, if_err,
        output d_req, d_op, d_read_type, d_wmask, d_addr, d_wdata,
        input  d_done, d_rdata, d_err,
        input  m_req, m_we, m_addr, m_be, m_wdata,
        output m_ready, m_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane helper for the memory port sequencer.
// Ports:
//   addr_lo       in  2   byte offset within the word
//   read_type     in  3   MEM_RD_* code (MEM_RD_NONE when the access is a store)
//   wmask         in  4   MEM_WR_* code (MEM_WR_NONE when the access is a load)
//   wdata         in  32  right-justified store data
//   rdata         in  32  raw memory word
//   be            out 4   store byte enables, wmask shifted onto its lanes
//   wdata_aligned out 32  store data replicated across all lanes
//   rdata_ext     out 32  selected lanes, sign/zero-extended
//   misalign      out 1   access does not fit its natural alignment
module mem_lane_align
    import mem_port_sequencer_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  read_type,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_aligned,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [31:0] word_s;
    logic        rd_misalign_s;
    logic        wr_misalign_s;

    // Store lanes: shift the mask, replicate the data so every lane carries it
    always_comb begin
        be            = wmask << addr_lo;
        wdata_aligned = 32'h0000_0000;
        case (wmask)
            MEM_WR_SB: wdata_aligned = {4{wdata[7:0]}};
            MEM_WR_SH: wdata_aligned = {2{wdata[15:0]}};
            MEM_WR_SW: wdata_aligned = wdata;
            default:   wdata_aligned = 32'h0000_0000;
        endcase
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend
    always_comb begin
        word_s    = rdata >> {addr_lo, 3'b000};
        rdata_ext = 32'h0000_0000;
        case (read_type)
            MEM_RD_LB:  rdata_ext = {{24{word_s[7]}}, word_s[7:0]};
            MEM_RD_LH:  rdata_ext = {{16{word_s[15]}}, word_s[15:0]};
            MEM_RD_LW:  rdata_ext = word_s;
            MEM_RD_LBU: rdata_ext = {24'h00_0000, word_s[7:0]};
            MEM_RD_LHU: rdata_ext = {16'h0000, word_s[15:0]};
            default:    rdata_ext = 32'h0000_0000;
        endcase
    end

    // Alignment: halfwords need an even address, words a multiple of four
    always_comb begin
        rd_misalign_s = 1'b0;
        wr_misalign_s = 1'b0;
        case (read_type)
            MEM_RD_LH, MEM_RD_LHU: rd_misalign_s = addr_lo[0];
            MEM_RD_LW:             rd_misalign_s = (addr_lo != 2'b00);
            default:               rd_misalign_s = 1'b0;
        endcase
        case (wmask)
            MEM_WR_SH: wr_misalign_s = addr_lo[0];
            MEM_WR_SW: wr_misalign_s = (addr_lo != 2'b00);
            default:   wr_misalign_s = 1'b0;
        endcase
        misalign = rd_misalign_s | wr_misalign_s;
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// Memory port sequencer.
// Shares one single-port, variable-latency memory between instruction fetch
// and load/store. Data requests win over fetch. Stores are lane-aligned,
// loads are extended, misaligned/invalid accesses are answered without
// touching memory, and a stalled memory is abandoned after TIMEOUT_CYCLES.
// Ports:
//   clk  in  clock, everything updates on the rising edge
//   rst  in  synchronous active-high reset
//   bus  master modport of mem_port_sequencer_if (if_*, d_*, m_* signals)
module mem_port_sequencer
    import mem_port_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_sequencer_if.master bus
);

    // Last BUSY count at which a still-silent memory is abandoned
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    logic [1:0]  state_r;
    logic        owner_r;
    logic [7:0]  cnt_r;
    logic [1:0]  cap_lane_r;
    logic [2:0]  cap_rt_r;

    logic        if_done_r;
    logic        if_err_r;
    logic [31:0] if_rdata_r;
    logic        d_done_r;
    logic        d_err_r;
    logic [31:0] d_rdata_r;
    logic        m_req_r;
    logic        m_we_r;
    logic [31:0] m_addr_r;
    logic [3:0]  m_be_r;
    logic [31:0] m_wdata_r;

    logic        d_valid_s;
    logic        win_any_s;
    logic        win_store_s;
    logic [31:0] win_addr_s;
    logic [1:0]  lane_s;
    logic [2:0]  rt_s;
    logic [3:0]  wm_s;
    logic        bad_code_s;
    logic        fault_s;
    logic [3:0]  align_be_s;
    logic [31:0] align_wdata_s;
    logic [31:0] align_rdata_s;
    logic        align_misalign_s;
    mem_cmd_t    cmd_s;

    // Arbitration: a data request with a real op beats fetch
    always_comb begin
        d_valid_s   = bus.d_req && ((bus.d_op == MEM_OP_LOAD) || (bus.d_op == MEM_OP_STORE));
        win_any_s   = d_valid_s || bus.if_req;
        win_store_s = d_valid_s && (bus.d_op == MEM_OP_STORE);
        win_addr_s  = d_valid_s ? bus.d_addr : bus.if_addr;
    end

    // Lane helper inputs: the live winner in IDLE, the captured access afterwards.
    // A fetch is a word load; a store presents no read code so only the store
    // alignment rule applies to it.
    always_comb begin
        lane_s = cap_lane_r;
        rt_s   = cap_rt_r;
        wm_s   = MEM_WR_NONE;
        if (state_r == SEQ_IDLE) begin
            lane_s = win_addr_s[1:0];
            if (!d_valid_s) begin
                rt_s = MEM_RD_LW;
            end else if (win_store_s) begin
                rt_s = MEM_RD_NONE;
            end else begin
                rt_s = bus.d_read_type;
            end
            wm_s = win_store_s ? bus.d_wmask : MEM_WR_NONE;
        end else begin
            lane_s = cap_lane_r;
            rt_s   = cap_rt_r;
            wm_s   = MEM_WR_NONE;
        end
    end

    mem_lane_align u_lane_align (
        .addr_lo       (lane_s),
        .read_type     (rt_s),
        .wmask         (wm_s),
        .wdata         (bus.d_wdata),
        .rdata         (bus.m_rdata),
        .be            (align_be_s),
        .wdata_aligned (align_wdata_s),
        .rdata_ext     (align_rdata_s),
        .misalign      (align_misalign_s)
    );

    // Fault decision and the command that would be launched for the winner
    always_comb begin
        if (d_valid_s) begin
            bad_code_s = win_store_s ? !wr_code_valid(bus.d_wmask) : !rd_code_valid(bus.d_read_type);
        end else begin
            bad_code_s = 1'b0;
        end
        fault_s     = align_misalign_s || bad_code_s;
        cmd_s.we    = win_store_s;
        cmd_s.addr  = {win_addr_s[31:2], 2'b00};
        cmd_s.be    = win_store_s ? align_be_s : 4'b1111;
        cmd_s.wdata = win_store_s ? align_wdata_s : 32'h0000_0000;
    end

    // Sequencer FSM, owner, timeout counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= SEQ_IDLE;
            owner_r    <= SEQ_OWNER_IF;
            cnt_r      <= 8'd0;
            cap_lane_r <= 2'b00;
            cap_rt_r   <= MEM_RD_NONE;
            if_done_r  <= 1'b0;
            if_err_r   <= 1'b0;
            if_rdata_r <= 32'h0000_0000;
            d_done_r   <= 1'b0;
            d_err_r    <= 1'b0;
            d_rdata_r  <= 32'h0000_0000;
            m_req_r    <= 1'b0;
            m_we_r     <= 1'b0;
            m_addr_r   <= 32'h0000_0000;
            m_be_r     <= 4'b0000;
            m_wdata_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                SEQ_IDLE: begin
                    if (win_any_s) begin
                        owner_r    <= d_valid_s ? SEQ_OWNER_D : SEQ_OWNER_IF;
                        cap_lane_r <= win_addr_s[1:0];
                        cap_rt_r   <= rt_s;
                        if (fault_s) begin
                            // Answer immediately; memory is never asked
                            state_r    <= SEQ_RESP;
                            if_done_r  <= !d_valid_s;
                            if_err_r   <= !d_valid_s;
                            d_done_r   <= d_valid_s;
                            d_err_r    <= d_valid_s;
                            if_rdata_r <= 32'h0000_0000;
                            d_rdata_r  <= 32'h0000_0000;
                        end else begin
                            state_r   <= SEQ_BUSY;
                            m_req_r   <= 1'b1;
                            m_we_r    <= cmd_s.we;
                            m_addr_r  <= cmd_s.addr;
                            m_be_r    <= cmd_s.be;
                            m_wdata_r <= cmd_s.wdata;
                            cnt_r     <= 8'd0;
                        end
                    end else begin
                        state_r <= SEQ_IDLE;
                    end
                end
                SEQ_BUSY: begin
                    if (bus.m_ready) begin
                        state_r <= SEQ_RESP;
                        m_req_r <= 1'b0;
                        if (owner_r == SEQ_OWNER_D) begin
                            d_done_r  <= 1'b1;
                            d_err_r   <= 1'b0;
                            d_rdata_r <= m_we_r ? 32'h0000_0000 : align_rdata_s;
                        end else begin
                            if_done_r  <= 1'b1;
                            if_err_r   <= 1'b0;
                            if_rdata_r <= align_rdata_s;
                        end
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        // Memory never answered: abandon the access
                        state_r    <= SEQ_RESP;
                        m_req_r    <= 1'b0;
                        if_done_r  <= (owner_r == SEQ_OWNER_IF);
                        if_err_r   <= (owner_r == SEQ_OWNER_IF);
                        d_done_r   <= (owner_r == SEQ_OWNER_D);
                        d_err_r    <= (owner_r == SEQ_OWNER_D);
                        if_rdata_r <= 32'h0000_0000;
                        d_rdata_r  <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                SEQ_RESP: begin
                    state_r   <= SEQ_IDLE;
                    if_done_r <= 1'b0;
                    if_err_r  <= 1'b0;
                    d_done_r  <= 1'b0;
                    d_err_r   <= 1'b0;
                    m_req_r   <= 1'b0;
                    cnt_r     <= 8'd0;
                end
                default: begin
                    state_r   <= SEQ_IDLE;
                    if_done_r <= 1'b0;
                    if_err_r  <= 1'b0;
                    d_done_r  <= 1'b0;
                    d_err_r   <= 1'b0;
                    m_req_r   <= 1'b0;
                    cnt_r     <= 8'd0;
                end
            endcase
        end
    end

    assign bus.if_done  = if_done_r;
    assign bus.if_err   = if_err_r;
    assign bus.if_rdata = if_rdata_r;
    assign bus.d_done   = d_done_r;
    assign bus.d_err    = d_err_r;
    assign bus.d_rdata  = d_rdata_r;
    assign bus.m_req    = m_req_r;
    assign bus.m_we     = m_we_r;
    assign bus.m_addr   = m_addr_r;
    assign bus.m_be     = m_be_r;
    assign bus.m_wdata  = m_wdata_r;

endmodule
